// File: rtl/score_bcd_counter.sv
// Two-digit BCD score counter with saturation, clear, and game-over blink for the seven-segment displays.
// Optional build macro SCORE_LEADING_ZERO_BLANK_EN enables the registered leading-zero blank on the tens digit.
module score_bcd_counter #(
    parameter int unsigned CLKS_PER_BLINK = 12500000,
    parameter int unsigned MAX_SCORE      = 99
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_score_inc,
    input  logic       i_score_clr,
    input  logic       i_game_over,
    output logic [3:0] o_tens,
    output logic [3:0] o_ones,
    output logic       o_blank,
    output logic       o_tens_blank,
    output logic       o_max
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BLINK);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BLINK - 1);
    localparam logic [3:0] MAX_TENS = 4'(MAX_SCORE / 10);
    localparam logic [3:0] MAX_ONES = 4'(MAX_SCORE % 10);

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_BLINK_ON  = 2'd1,
        ST_BLINK_OFF = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             inc_q;
    logic             inc_pulse_c;
    logic [3:0]       tens_q, tens_d;
    logic [3:0]       ones_q, ones_d;
    logic             max_q, max_d;
    logic             blank_q, blank_d;

    assign inc_pulse_c = i_score_inc & ~inc_q;

    // State, blink counter and increment edge-detect registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            inc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            inc_q   <= i_score_inc;
        end
    end

    // Next-state logic; the blink counter restarts from zero on every state change
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_RUN: begin
                cnt_d = '0;
                if (i_game_over) begin
                    state_d = ST_BLINK_ON;
                end
            end
            ST_BLINK_ON, ST_BLINK_OFF: begin
                if (!i_game_over) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = (state_q == ST_BLINK_ON) ? ST_BLINK_OFF : ST_BLINK_ON;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic: score arithmetic and blank, computed for the upcoming edge
    always_comb begin
        tens_d  = tens_q;
        ones_d  = ones_q;
        blank_d = (state_d == ST_BLINK_OFF);
        if (i_score_clr) begin
            tens_d = 4'd0;
            ones_d = 4'd0;
        end else if ((state_q == ST_RUN) && inc_pulse_c && !max_q) begin
            if (ones_q == 4'd9) begin
                ones_d = 4'd0;
                tens_d = tens_q + 4'd1;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end
        max_d = (tens_d == MAX_TENS) && (ones_d == MAX_ONES);
    end

    // Registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
            max_q   <= 1'b0;
            blank_q <= 1'b0;
        end else begin
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            max_q   <= max_d;
            blank_q <= blank_d;
        end
    end

`ifdef SCORE_LEADING_ZERO_BLANK_EN
    logic tens_blank_q;

    // Leading-zero suppression tracks the digits in the same cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tens_blank_q <= 1'b0;
        end else begin
            tens_blank_q <= (tens_d == 4'd0);
        end
    end

    assign o_tens_blank = tens_blank_q;
`else
    assign o_tens_blank = 1'b0;
`endif

    assign o_tens  = tens_q;
    assign o_ones  = ones_q;
    assign o_max   = max_q;
    assign o_blank = blank_q;

endmodule

// File: doc/score_bcd_counter.md
Name: score_bcd_counter

Overview:
- Upstream stage of the memory game's two seven-segment displays. Counts correct rounds as a two-digit BCD score (00..MAX_SCORE).
- Presents the tens and ones digits as 4-bit binary values. Each digit feeds its own binary-to-7-segment decoder.
- During game over, generates a blink enable that top level uses to gate segment outputs.

Parameters:
- CLKS_PER_BLINK, 12500000, clock cycles per blink half-period (0.5 s at 25 MHz); legal range 2..2^24-1.
- MAX_SCORE, 99, saturation value; legal range 1..99.

Ports:
- i_clk  input  1  system clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_score_inc  input  1  increment request; rising edge counted once; synchronous to i_clk.
- i_score_clr  input  1  synchronous clear; level-sensitive, one cycle is enough.
- i_game_over  input  1  level; high while game is in lost/over state.
- o_tens  output  4  tens digit, 0..9.
- o_ones  output  4  ones digit, 0..9.
- o_blank  output  1  1 = top level must turn all segments off.
- o_tens_blank  output  1  1 = tens display off (leading-zero suppression).
- o_max  output  1  1 = score equals MAX_SCORE (saturated).

Behaviour:
- Reset (async, i_rst_n=0):
  - o_tens=0, o_ones=0, o_blank=0, o_tens_blank=0, o_max=0.
  - Edge-detect register=0, blink counter=0, FSM=RUN.
- All outputs are registered; no combinational path from inputs to outputs.
- Increment:
  - inc_pulse = i_score_inc & ~r_inc_d (r_inc_d = i_score_inc delayed 1 cycle).
  - Holding i_score_inc high counts once.
  - Digits update on the clock edge after the edge where inc_pulse is first seen high (1-cycle latency from the input edge to the output change).
- BCD arithmetic:
  - ones 9 -> 0 with carry into tens; otherwise ones+1.
  - Binary codes 10..15 never appear on either digit.
- Saturation:
  - o_max = (score == MAX_SCORE), registered alongside the digits.
  - inc_pulse at MAX_SCORE is ignored; digits hold.
- Clear:
  - i_score_clr=1 forces digits to 00 and o_max to 0 on the next edge.
  - Clear wins over a simultaneous inc_pulse.
  - Clear is honoured in every FSM state and does not change the FSM state.
- FSM states RUN, BLINK_ON, BLINK_OFF:
  - RUN: o_blank=0; increments accepted. i_game_over=1 -> BLINK_ON, blink counter=0.
  - BLINK_ON: o_blank=0; increments ignored. Counter reaches CLKS_PER_BLINK-1 -> BLINK_OFF, counter=0.
  - BLINK_OFF: o_blank=1; increments ignored. Counter reaches CLKS_PER_BLINK-1 -> BLINK_ON, counter=0.
  - From BLINK_ON or BLINK_OFF, i_game_over=0 -> RUN on the next edge, o_blank=0. The score is retained; software/game FSM clears it explicitly.
- Blink counter: width $clog2(CLKS_PER_BLINK), wraps to 0 on every state change.
- Edge detector runs in all states. An inc edge that arrives during blink is discarded, not deferred.
- Reset mid-blink returns to RUN immediately (asynchronous).

Optional Feature:
- Macro: SCORE_LEADING_ZERO_BLANK_EN.
- Defined: o_tens_blank = (o_tens == 0), registered, updating in the same cycle as the digits. Score 07 shows a blank tens digit.
- Undefined: o_tens_blank tied to 0; no register is generated.
- o_blank behaviour is identical in both builds.

Test Plan (CLKS_PER_BLINK=4, MAX_SCORE=99 unless stated):
- Reset, then 12 single-cycle inc pulses -> o_tens=1, o_ones=2, o_max=0. Each digit changes 1 cycle after its pulse.
- i_score_inc held high for 20 cycles -> score increments exactly once (00 -> 01).
- MAX_SCORE=15, 20 pulses -> stops at tens=1, ones=5, o_max=1. Further pulses leave it unchanged.
- i_score_clr and an inc pulse in the same cycle at score 42 -> 00 next edge, o_max=0.
- Score 09, raise i_game_over:
  - o_blank sequence 0,0,0,0,1,1,1,1,0,... from entry into BLINK_ON.
  - Inc pulses during blink are ignored (stays 09).
  - Drop i_game_over -> o_blank=0 next edge, score still 09.
- SCORE_LEADING_ZERO_BLANK_EN defined: score 07 -> o_tens_blank=1; one more pulse to 08 keeps 1; pulses to 10 -> 0. Async reset asserted mid-BLINK_OFF -> all outputs 0 immediately.
